// File: rtl/block_sync_pkg.sv
// Shared definitions for the 64b/66b block-sync seeker.
//   c_DATA_HEADER / c_CMD_HEADER : the two legal 2-bit sync headers
//   hdr_valid()                  : true for either legal header
//   seeker_pos()                 : slice bit position tested by a lane at a given index
//   lock_state_t                 : lock FSM state encoding
package block_sync_pkg;

  localparam logic [1:0] c_DATA_HEADER = 2'b01;
  localparam logic [1:0] c_CMD_HEADER  = 2'b10;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } lock_state_t;

  function automatic logic hdr_valid(input logic [1:0] hdr);
    return (hdr == c_DATA_HEADER) || (hdr == c_CMD_HEADER);
  endfunction

  // Lane L walks positions L+1, L+1+N, L+1+2N, ...
  function automatic logic [6:0] seeker_pos(input int unsigned lane,
                                            input int unsigned idx,
                                            input int unsigned n_seekers = 6);
    return 7'(lane + 1 + idx * n_seekers);
  endfunction

endpackage

// File: rtl/block_sync_seeker_lane.sv
// One block-sync seeker lane: holds a position index and a run-length counter.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   en_i         : slice present and FSM searching; lane updates only then
//   clr_i        : clear counter and index (lock dropped)
//   slice_i      : registered BLK_W+1 bit slice under test
//   pos_o        : position currently tested (header = {slice[pos], slice[pos-1]})
//   hit_o        : counter saturated at LOCK_CNT
module seeker_lane
  import block_sync_pkg::*;
#(
  parameter int unsigned LANE      = 0,
  parameter int unsigned N_SEEKERS = 6,
  parameter int unsigned BLK_W     = 66,
  parameter int unsigned LOCK_CNT  = 32,
  parameter int unsigned CNT_W     = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [BLK_W:0]   slice_i,
  output logic [6:0]       pos_o,
  output logic             hit_o
);

  // Highest index whose position still fits within the block.
  localparam int unsigned LAST_IDX = (BLK_W - LANE - 1) / N_SEEKERS;
  localparam int unsigned IDX_W    = (LAST_IDX > 0) ? $clog2(LAST_IDX + 1) : 1;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       hdr;

  assign pos_o = seeker_pos(LANE, 32'(idx_q), N_SEEKERS);
  assign hdr   = 2'(slice_i >> (pos_o - 7'd1));
  assign hit_o = (cnt_q == CNT_W'(LOCK_CNT));

  always_comb begin
    idx_d = idx_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      idx_d = '0;
      cnt_d = '0;
    end else if (en_i) begin
      if (hdr_valid(hdr)) begin
        if (!hit_o) cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = '0;
        idx_d = (idx_q == IDX_W'(LAST_IDX)) ? '0 : idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_q <= '0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/block_sync_seeker.sv
// 64b/66b block-sync header seeker with lock/unlock state machine.
// N_SEEKERS lanes hunt in parallel for a position that carries a valid sync
// header LOCK_CNT slices in a row; the winning position is then monitored and
// UNLOCK_BAD consecutive bad headers restart the hunt.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   gbox_buffer   : complete gearbox buffer
//   gbox_cnt      : window index, slice = gbox_buffer[BUF_W-1-gbox_cnt -: BLK_W+1]
//   buffer_dv     : gbox_buffer/gbox_cnt valid this cycle
//   block_offset  : header offset within slice (position - 1)
//   locked        : block lock achieved
//   lock_lost     : one-cycle pulse on LOCKED -> SEARCH
//
// state  | meaning
// SEARCH | lanes hunting; first saturated lane (lowest index) wins
// LOCKED | lanes frozen; header at block_offset+1 checked on every slice
module block_sync_seeker
  import block_sync_pkg::*;
#(
  parameter int unsigned BUF_W      = 194,
  parameter int unsigned BLK_W      = 66,
  parameter int unsigned N_SEEKERS  = 6,
  parameter int unsigned LOCK_CNT   = 32,
  parameter int unsigned UNLOCK_BAD = 4,
  parameter int unsigned CNT_W      = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [BUF_W-1:0] gbox_buffer,
  input  logic [5:0]       gbox_cnt,
  input  logic             buffer_dv,
  output logic [6:0]       block_offset,
  output logic             locked,
  output logic             lock_lost
);

  localparam int unsigned BAD_W = $clog2(UNLOCK_BAD + 1);
  localparam int unsigned WIN_W = $clog2(BUF_W) + 1;

  lock_state_t      state_q, state_d;
  logic [BLK_W:0]   slice_q, slice_d;
  logic             slice_vld_q, slice_vld_d;
  logic [BAD_W-1:0] bad_q, bad_d;
  logic [6:0]       off_q, off_d;
  logic             lost_q, lost_d;

  logic [WIN_W-1:0] top_idx;
  logic [WIN_W-1:0] shift_amt;
  logic             win_ok;
  logic [BLK_W:0]   win_slice;

  logic [6:0]           lane_pos [N_SEEKERS];
  logic [N_SEEKERS-1:0] lane_hit;
  logic                 lane_en;
  logic                 lane_clr;
  logic                 any_hit;
  logic [6:0]           hit_pos;
  logic [1:0]           lock_hdr;

  // Window is legal only while its lowest bit stays inside the buffer.
  assign top_idx   = WIN_W'(BUF_W - 1) - WIN_W'(gbox_cnt);
  assign win_ok    = (top_idx >= WIN_W'(BLK_W));
  assign shift_amt = WIN_W'(BUF_W - BLK_W - 1) - WIN_W'(gbox_cnt);
  assign win_slice = (BLK_W+1)'(gbox_buffer >> shift_amt);

  always_comb begin
    slice_d     = slice_q;
    slice_vld_d = 1'b0;
    if (buffer_dv && win_ok) begin
      slice_d     = win_slice;
      slice_vld_d = 1'b1;
    end
  end

  assign lane_en = slice_vld_q && (state_q == SEARCH);

  for (genvar g = 0; g < N_SEEKERS; g++) begin : g_lane
    seeker_lane #(
      .LANE      (g),
      .N_SEEKERS (N_SEEKERS),
      .BLK_W     (BLK_W),
      .LOCK_CNT  (LOCK_CNT),
      .CNT_W     (CNT_W)
    ) u_lane (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .en_i    (lane_en),
      .clr_i   (lane_clr),
      .slice_i (slice_q),
      .pos_o   (lane_pos[g]),
      .hit_o   (lane_hit[g])
    );
  end

  // Scan from the top down so the lowest hitting lane is written last.
  always_comb begin
    any_hit = 1'b0;
    hit_pos = '0;
    for (int i = int'(N_SEEKERS) - 1; i >= 0; i--) begin
      if (lane_hit[i]) begin
        any_hit = 1'b1;
        hit_pos = lane_pos[i];
      end
    end
  end

  assign lock_hdr = 2'(slice_q >> off_q);

  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    bad_d    = bad_q;
    lost_d   = 1'b0;
    lane_clr = 1'b0;
    case (state_q)
      SEARCH: begin
        if (any_hit) begin
          state_d = LOCKED;
          off_d   = hit_pos - 7'd1;
          bad_d   = '0;
        end
      end
      LOCKED: begin
        if (slice_vld_q) begin
          if (hdr_valid(lock_hdr)) begin
            bad_d = '0;
          end else if (bad_q == BAD_W'(UNLOCK_BAD - 1)) begin
            state_d  = SEARCH;
            bad_d    = '0;
            lost_d   = 1'b1;
            lane_clr = 1'b1;
          end else begin
            bad_d = bad_q + BAD_W'(1);
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= SEARCH;
      slice_q     <= '0;
      slice_vld_q <= 1'b0;
      bad_q       <= '0;
      off_q       <= '0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      slice_q     <= slice_d;
      slice_vld_q <= slice_vld_d;
      bad_q       <= bad_d;
      off_q       <= off_d;
      lost_q      <= lost_d;
    end
  end

  assign locked       = (state_q == LOCKED);
  assign block_offset = off_q;
  assign lock_lost    = lost_q;

endmodule

// File: tb/tb_block_sync_seeker.sv
module tb_block_sync_seeker;

  localparam int BUF_W = 194;
  localparam int BLK_W = 66;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [BUF_W-1:0] gbuf = '0;
  logic [5:0]       gcnt = '0;
  logic             dv = 1'b0;
  logic [6:0]       block_offset;
  logic             locked;
  logic             lock_lost;

  always #5 clk = ~clk;

  block_sync_seeker dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .gbox_buffer  (gbuf),
    .gbox_cnt     (gcnt),
    .buffer_dv    (dv),
    .block_offset (block_offset),
    .locked       (locked),
    .lock_lost    (lock_lost)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       lk;
    logic       ll;
    logic [6:0] off;
    int         at;
  } ev_t;

  ev_t   exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    mon_en = 1'b0;
  int    last_drive = 0;

  // Monitor: every change of the output triple must match the next expected event.
  logic [8:0] prev_out;
  logic [8:0] cur_out;
  ev_t        mon_e;
  string      mon_n;
  always @(negedge clk) begin
    cur_out = {locked, lock_lost, block_offset};
    if (mon_en && (cur_out !== prev_out)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d got locked=%b lock_lost=%b offset=%0d",
                 cyc, locked, lock_lost, block_offset);
      end else begin
        mon_e = exp_q.pop_front();
        mon_n = name_q.pop_front();
        if (mon_e.lk !== locked || mon_e.ll !== lock_lost ||
            mon_e.off !== block_offset || mon_e.at != cyc) begin
          errors++;
          $display("FAIL %s got locked=%b lock_lost=%b offset=%0d cyc=%0d expected locked=%b lock_lost=%b offset=%0d cyc=%0d",
                   mon_n, locked, lock_lost, block_offset, cyc,
                   mon_e.lk, mon_e.ll, mon_e.off, mon_e.at);
        end
      end
    end
    prev_out = cur_out;
  end

  task automatic push_exp(input logic lk, input logic ll, input int off, input int at,
                          input string nm);
    ev_t e;
    e.lk  = lk;
    e.ll  = ll;
    e.off = 7'(off);
    e.at  = at;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Place a slice in the window selected by cnt; everything outside the window is ones.
  function automatic logic [BUF_W-1:0] make_buf(input logic [BLK_W:0] s, input int cnt);
    logic [BUF_W-1:0] m;
    logic [BUF_W-1:0] v;
    int sh;
    sh = BUF_W - BLK_W - 1 - cnt;
    m  = {{(BUF_W-BLK_W-1){1'b0}}, {(BLK_W+1){1'b1}}} << sh;
    v  = {{(BUF_W-BLK_W-1){1'b0}}, s} << sh;
    return ({BUF_W{1'b1}} & ~m) | v;
  endfunction

  function automatic logic [BLK_W:0] hdr_slice(input int p, input logic [1:0] hdr);
    logic [BLK_W:0] s;
    s        = '0;
    s[p]     = hdr[1];
    s[p - 1] = hdr[0];
    return s;
  endfunction

  // Called just after a falling edge; dv high for exactly one rising edge.
  task automatic send(input logic [BLK_W:0] s, input int cnt, input int gap);
    gbuf       = make_buf(s, cnt);
    gcnt       = 6'(cnt);
    dv         = 1'b1;
    last_drive = cyc;
    @(negedge clk);
    dv = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // Alternating data/cmd headers at position p keep only p valid on every slice.
  task automatic stream(input int p, input int cnt, input int n, input int gap,
                        input bit exp_lock, input string nm);
    logic [1:0] h;
    for (int k = 0; k < n; k++) begin
      h = (k % 2 == 0) ? 2'b01 : 2'b10;
      if (exp_lock && k == n - 1) push_exp(1'b1, 1'b0, p - 1, cyc + 3, nm);
      send(hdr_slice(p, h), cnt, gap);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset(input bit expect_change, input string nm);
    rst = 1'b1;
    if (expect_change) push_exp(1'b0, 1'b0, 0, cyc + 1, nm);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
  endtask

  logic [BLK_W:0] bad_s;
  logic [BLK_W:0] t4_s;
  int d4;

  initial begin
    bad_s = '0;
    t4_s  = '0;
    t4_s[5] = 1'b1;
    t4_s[9] = 1'b1;

    repeat (3) @(negedge clk);
    checks++;
    if (locked !== 1'b0 || lock_lost !== 1'b0 || block_offset !== 7'd0) begin
      errors++;
      $display("FAIL reset_state got locked=%b lock_lost=%b offset=%0d expected 0 0 0",
               locked, lock_lost, block_offset);
    end
    rst    = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // Clean stream, header at 37: lane 0 needs 6 slices to reach it plus 32 valid.
    stream(37, 0, 38, 0, 1'b1, "t1_lock");
    idle(8);

    // 3 bad + 1 good keeps lock.
    for (int k = 0; k < 3; k++) send(bad_s, 0, 0);
    stream(37, 0, 1, 0, 1'b0, "");
    idle(5);
    checks++;
    if (locked !== 1'b1 || block_offset !== 7'd36) begin
      errors++;
      $display("FAIL t2_hold got locked=%b offset=%0d expected locked=1 offset=36",
               locked, block_offset);
    end

    // 4 consecutive bad drop lock, then relock on the same position.
    for (int k = 0; k < 4; k++) send(bad_s, 0, 0);
    d4 = last_drive;
    push_exp(1'b0, 1'b1, 36, d4 + 2, "t2_lost_rise");
    push_exp(1'b0, 1'b0, 36, d4 + 3, "t2_lost_fall");
    stream(37, 0, 38, 0, 1'b1, "t2_relock");
    idle(8);

    // Reset while locked.
    pulse_reset(1'b1, "t5_reset");

    // Sparse dv (1 in 8), header at 20 behind window 17: 3 slices to arrive + 32.
    stream(20, 17, 35, 7, 1'b1, "t3_sparse_lock");
    idle(4);
    pulse_reset(1'b1, "t3_reset");

    // Positions 5/6 (lanes 4,5) tie on slice 32; 9/10 saturate one slice later.
    for (int k = 0; k < 32; k++) begin
      if (k == 31) push_exp(1'b1, 1'b0, 4, cyc + 3, "t4_tie_lock");
      send(t4_s, 40, 0);
    end
    idle(8);
    pulse_reset(1'b1, "t4_reset");

    // Highest legal window index, header at the last position 66.
    stream(66, 63, 42, 0, 1'b1, "t6_edge_lock");
    idle(10);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events got %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
